ksubs3_noc16_tx_arbiter: RTL and testbench
==========================================

Name: ksubs3_noc16_tx_arbiter

Overview:
- Round-robin arbiter sharing the single Ksubs3 Noc16 Tx channel between NREQ requesters inside the innercore. Typical requesters are director shim responses, PIO replies and user kernels.
- Grants whole packets. A grant stays locked until the beat flagged last is accepted, so beats from different requesters never interleave.
- Sits between the requesters and the Noc16 TxData_lo/cmd/valid/rdy port that feeds the AXI PIO target.
- Provides a per-packet beat watchdog and a packet counter for monitoring.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXBEATS, 16, maximum beats per packet before forced release (1..255).

Ports:
- clk  in  1  clock.
- ARESET_N  in  1  synchronous active-low reset.
- req_lo  in  NREQ*64  payload; requester i occupies bits [64i+63:64i].
- req_cmd  in  NREQ*8  command byte; requester i occupies bits [8i+7:8i].
- req_last  in  NREQ  final beat of packet.
- req_valid  in  NREQ  beat valid.
- req_rdy  out  NREQ  beat accepted (per requester).
- tx_lo  out  64  Noc16 TxData_lo.
- tx_cmd  out  8  Noc16 TxData_cmd.
- tx_valid  out  1  Noc16 TxData_valid.
- tx_rdy  in  1  Noc16 TxData_rdy.
- grant_valid  out  1  a packet is currently locked.
- grant_id  out  3  index of the locked requester.
- overrun  out  1  sticky: a packet exceeded MAXBEATS.
- pkt_count  out  32  number of completed packets.

Behaviour:
- Clocking: all state updates on posedge clk. Reset is synchronous, active-low, ARESET_N, clock clk.
- Reset values:
  - state=IDLE, rr_ptr=NREQ-1 (so requester 0 wins first), beat_cnt=0.
  - grant_valid=0, grant_id=0, overrun=0, pkt_count=0.
  - tx_valid=0, req_rdy=0.
- States: IDLE, LOCKED.
- IDLE:
  - tx_valid=0 and req_rdy=0.
  - If any req_valid is high, grant the first set index searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - Registered grant: grant_id<=winner, grant_valid<=1, beat_cnt<=0, go to LOCKED.
  - Grant latency is 1 cycle from req_valid to tx_valid. No beat is transferred in the IDLE cycle.
- LOCKED, with g=grant_id (combinational passthrough, zero added latency):
  - tx_lo=req_lo[g], tx_cmd=req_cmd[g], tx_valid=req_valid[g].
  - req_rdy[g]=tx_rdy. Every other req_rdy bit is 0.
- Beat transfer: occurs when tx_valid && tx_rdy.
  - Each beat increments beat_cnt (8-bit).
  - Packet end is a transferred beat with req_last[g]=1, or a transferred beat with beat_cnt==MAXBEATS-1 (forced end).
  - At packet end: state<=IDLE, grant_valid<=0, rr_ptr<=g, pkt_count<=pkt_count+1 (wraps 2^32-1 -> 0).
  - Forced end without last: overrun<=1 (sticky until reset). Remaining beats of that requester are then arbitrated as a new packet.
- Requester dropping req_valid mid-packet: the grant stays locked. tx_valid follows req_valid[g] and no timeout applies.
- A requester withdrawing req_valid in the same cycle it wins in IDLE: it is still granted, and LOCKED simply waits.
- Single active requester: it is re-granted after every packet, with 1 idle cycle between packets.
- tx_rdy low in LOCKED: no transfer, beat_cnt holds, no data is lost. The payload is the live requester data, which requesters must hold stable while valid.
- ARESET_N low mid-packet: returns to IDLE next edge with all reset values. Any partially sent packet is abandoned.
- grant_id is 3 bits regardless of NREQ. Unused upper bits are 0.

Test Plan:
- Fairness:
  - Stimulus: all 4 requesters hold valid with 1-beat packets (last=1), tx_rdy=1.
  - Required: grant order 0,1,2,3,0,…; each beat is followed by 1 idle cycle; pkt_count=8 after 16 cycles.
- Packet lock:
  - Stimulus: req1 sends a 3-beat packet while req0 and req2 are valid.
  - Required: tx shows req1's three beats contiguously with no interleaving; the next grant is req2.
- Backpressure:
  - Stimulus: tx_rdy toggles 1,0,0,1 during a 2-beat packet from req3 with lo=0xA5A5_0000_0000_0001 then ..._0002.
  - Required: beats appear in order exactly once; req_rdy[3] mirrors tx_rdy; all other req_rdy bits stay 0.
- Watchdog:
  - Stimulus: MAXBEATS=16, req0 sends 20 beats with last=0.
  - Required: release after beat 16; overrun=1; pkt_count increments by 1; beats 17–20 are sent as a new granted packet.
- Reset mid-packet:
  - Stimulus: ARESET_N=0 for 1 cycle after beat 2 of 4.
  - Required: next cycle tx_valid=0, grant_valid=0, pkt_count=0, overrun=0; the first grant after reset goes to req0 if it is valid.
- Wrap:
  - Stimulus: force pkt_count=0xFFFF_FFFF, then complete one packet.
  - Required: pkt_count=0.

Source files
------------

// File: rtl/ksubs3_noc16_tx_arbiter_if.sv
// Requester-side and Noc16 Tx-side bundle for the Tx channel arbiter.
// master: the arbiter's view; slave: the requesters + Noc16 port view.
interface ksubs3_noc16_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ*64-1:0] req_lo;
    logic [NREQ*8-1:0]  req_cmd;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_rdy;
    logic [63:0]        tx_lo;
    logic [7:0]         tx_cmd;
    logic               tx_valid;
    logic               tx_rdy;

    modport master (
        input  req_lo, req_cmd, req_last, req_valid, tx_rdy,
        output req_rdy, tx_lo, tx_cmd, tx_valid
    );

    modport slave (
        output req_lo, req_cmd, req_last, req_valid, tx_rdy,
        input  req_rdy, tx_lo, tx_cmd, tx_valid
    );
endinterface

// File: rtl/ksubs3_noc16_tx_arbiter.sv
// Packet-granular round-robin arbiter for the Ksubs3 Noc16 Tx channel.
// A grant is locked from the IDLE arbitration cycle until the last beat
// (or the MAXBEATS-th beat) is accepted; the data path is a pure mux.
module ksubs3_noc16_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAXBEATS = 16
) (
    input  logic                             clk,
    input  logic                             ARESET_N,
    ksubs3_noc16_tx_arbiter_if.master        bus,
    output logic                             grant_valid,
    output logic [2:0]                       grant_id,
    output logic                             overrun,
    output logic [31:0]                      pkt_count
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    logic [2:0]              rr_ptr;
    logic [7:0]              beat_cnt;

    logic [NREQ-1:0][63:0]   lo_arr;
    logic [NREQ-1:0][7:0]    cmd_arr;
    logic [IW-1:0]           gsel;
    logic                    locked;
    logic                    xfer;
    logic                    pkt_end;
    logic                    win_found;
    logic [2:0]              win;

    assign lo_arr  = bus.req_lo;
    assign cmd_arr = bus.req_cmd;
    assign gsel    = grant_id[IW-1:0];
    assign locked  = (state == LOCKED);

    // Zero-latency passthrough of the locked requester; everything idle otherwise.
    always_comb begin
        bus.tx_lo    = '0;
        bus.tx_cmd   = '0;
        bus.tx_valid = 1'b0;
        bus.req_rdy  = '0;
        if (locked) begin
            bus.tx_lo       = lo_arr[gsel];
            bus.tx_cmd      = cmd_arr[gsel];
            bus.tx_valid    = bus.req_valid[gsel];
            bus.req_rdy[gsel] = bus.tx_rdy;
        end
    end

    assign xfer    = locked && bus.tx_valid && bus.tx_rdy;
    // The MAXBEATS-th beat ends the packet whether or not it carries last.
    assign pkt_end = xfer && (bus.req_last[gsel] || (beat_cnt == 8'(MAXBEATS - 1)));

    // Round-robin search starting just after the previous winner.
    always_comb begin
        logic [IW-1:0] idx;
        win_found = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win       = 3'(idx);
            end
        end
    end

    // Grant FSM, beat watchdog and packet accounting.
    always_ff @(posedge clk) begin
        if (!ARESET_N) begin
            state       <= IDLE;
            rr_ptr      <= 3'(NREQ - 1);
            beat_cnt    <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            overrun     <= 1'b0;
            pkt_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_id    <= win;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (pkt_end) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                            rr_ptr      <= grant_id;
                            pkt_count   <= pkt_count + 32'd1;
                            if (!bus.req_last[gsel])
                                overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ksubs3_noc16_tx_arbiter.sv
// Directed bench: a per-cycle vector table for fairness / packet lock,
// then hand sequences for backpressure, watchdog, reset and counter wrap.
module tb_ksubs3_noc16_tx_arbiter;
    logic        clk;
    logic        ARESET_N;
    logic        grant_valid;
    logic [2:0]  grant_id;
    logic        overrun;
    logic [31:0] pkt_count;

    int errors = 0;
    int checks = 0;

    ksubs3_noc16_tx_arbiter_if #(.NREQ(4)) bus();

    ksubs3_noc16_tx_arbiter #(.NREQ(4), .MAXBEATS(16)) dut (
        .clk         (clk),
        .ARESET_N    (ARESET_N),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .overrun     (overrun),
        .pkt_count   (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        rdy;
        logic        e_txv;
        logic [3:0]  e_rdy;
        logic        e_gv;
        logic [2:0]  e_gid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [23];

    function automatic logic [63:0] lo_of(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'h1111_1111 * 32'(i + 1)};
    endfunction

    function automatic logic [7:0] cmd_of(input int i);
        return 8'(8'h10 + i);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // From negedge+1 to the next negedge (one rising edge in between).
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int nbeats;
        logic [3:0] bp_pat;

        // Fairness: 1-beat packets from all four requesters.
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 3'd0, 32'd0};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd1};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 3'd1, 32'd1};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd2};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 3'd2, 32'd2};
        tbl[6]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd3};
        tbl[7]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 3'd3, 32'd3};
        tbl[8]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd4};
        tbl[9]  = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 3'd0, 32'd4};
        tbl[10] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd5};
        tbl[11] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 3'd1, 32'd5};
        tbl[12] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd6};
        tbl[13] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 3'd2, 32'd6};
        tbl[14] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd7};
        tbl[15] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 3'd3, 32'd7};
        // Packet lock: req1 3-beat packet with req0/req2 also valid; req2 next.
        tbl[16] = '{4'h2, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd8};
        tbl[17] = '{4'h7, 4'h5, 1'b1, 1'b1, 4'h2, 1'b1, 3'd1, 32'd8};
        tbl[18] = '{4'h7, 4'h5, 1'b1, 1'b1, 4'h2, 1'b1, 3'd1, 32'd8};
        tbl[19] = '{4'h7, 4'h7, 1'b1, 1'b1, 4'h2, 1'b1, 3'd1, 32'd8};
        tbl[20] = '{4'h5, 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd9};
        tbl[21] = '{4'h5, 4'h5, 1'b1, 1'b1, 4'h4, 1'b1, 3'd2, 32'd9};
        tbl[22] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 32'd10};

        ARESET_N      = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.tx_rdy    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_lo[i*64 +: 64] = lo_of(i);
            bus.req_cmd[i*8 +: 8]  = cmd_of(i);
        end

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_txv",  64'(bus.tx_valid), 64'd0);
        chk("rst_rdy",  64'(bus.req_rdy),  64'd0);
        chk("rst_gv",   64'(grant_valid),  64'd0);
        chk("rst_gid",  64'(grant_id),     64'd0);
        chk("rst_ovr",  64'(overrun),      64'd0);
        chk("rst_pc",   64'(pkt_count),    64'd0);
        ARESET_N = 1'b1;

        // Table-driven cycles.
        for (int i = 0; i < 23; i++) begin
            bus.req_valid = tbl[i].valid;
            bus.req_last  = tbl[i].last;
            bus.tx_rdy    = tbl[i].rdy;
            #1;
            chk($sformatf("r%0d_txv", i), 64'(bus.tx_valid), 64'(tbl[i].e_txv));
            chk($sformatf("r%0d_rdy", i), 64'(bus.req_rdy),  64'(tbl[i].e_rdy));
            chk($sformatf("r%0d_gv", i),  64'(grant_valid),  64'(tbl[i].e_gv));
            chk($sformatf("r%0d_pc", i),  64'(pkt_count),    64'(tbl[i].e_pc));
            if (tbl[i].e_gv)
                chk($sformatf("r%0d_gid", i), 64'(grant_id), 64'(tbl[i].e_gid));
            if (tbl[i].e_txv) begin
                chk($sformatf("r%0d_lo", i),  bus.tx_lo,         lo_of(int'(tbl[i].e_gid)));
                chk($sformatf("r%0d_cmd", i), 64'(bus.tx_cmd),   64'(cmd_of(int'(tbl[i].e_gid))));
            end
            tick();
        end

        // Backpressure: req3 2-beat packet, tx_rdy 1,0,0,1.
        bus.req_valid = 4'b1000;
        bus.req_last  = 4'b0000;
        bus.tx_rdy    = 1'b1;
        bus.req_lo[255:192] = 64'hA5A5_0000_0000_0001;
        #1;
        chk("bp_idle_txv", 64'(bus.tx_valid), 64'd0);
        tick();
        bp_pat = 4'b1001;
        nbeats = 0;
        for (int k = 0; k < 4; k++) begin
            bus.tx_rdy = bp_pat[k];
            if (k == 1) begin
                bus.req_lo[255:192] = 64'hA5A5_0000_0000_0002;
                bus.req_last        = 4'b1000;
            end
            #1;
            chk($sformatf("bp%0d_txv", k), 64'(bus.tx_valid), 64'd1);
            chk($sformatf("bp%0d_rdy", k), 64'(bus.req_rdy),   64'({bp_pat[k], 3'b000}));
            chk($sformatf("bp%0d_lo", k),  bus.tx_lo,
                (k == 0) ? 64'hA5A5_0000_0000_0001 : 64'hA5A5_0000_0000_0002);
            if (bus.tx_valid && bus.tx_rdy)
                nbeats++;
            tick();
        end
        chk("bp_nbeats", 64'(nbeats), 64'd2);
        bus.req_valid = 4'b0000;
        #1;
        chk("bp_gv_after", 64'(grant_valid), 64'd0);
        chk("bp_pc_after", 64'(pkt_count),   64'd11);
        tick();

        // Watchdog: req0 streams 20 beats with last=0.
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0000;
        bus.tx_rdy    = 1'b1;
        bus.req_lo[63:0] = 64'd0;
        #1;
        chk("wd_idle_txv", 64'(bus.tx_valid), 64'd0);
        tick();
        for (int b = 1; b <= 16; b++) begin
            bus.req_lo[63:0] = 64'(b);
            #1;
            chk($sformatf("wd_b%0d_txv", b), 64'(bus.tx_valid), 64'd1);
            chk($sformatf("wd_b%0d_lo", b),  bus.tx_lo,         64'(b));
            chk($sformatf("wd_b%0d_ovr", b), 64'(overrun),      64'd0);
            tick();
        end
        #1;
        chk("wd_rel_gv",  64'(grant_valid),  64'd0);
        chk("wd_rel_txv", 64'(bus.tx_valid), 64'd0);
        chk("wd_ovr",     64'(overrun),      64'd1);
        chk("wd_pc",      64'(pkt_count),    64'd12);
        tick();
        for (int b = 17; b <= 20; b++) begin
            bus.req_lo[63:0] = 64'(b);
            #1;
            chk($sformatf("wd_b%0d_txv", b), 64'(bus.tx_valid), 64'd1);
            chk($sformatf("wd_b%0d_gid", b), 64'(grant_id),     64'd0);
            chk($sformatf("wd_b%0d_lo", b),  bus.tx_lo,         64'(b));
            tick();
        end
        bus.req_valid = 4'b0000;
        #1;
        chk("wd_hold_gv",  64'(grant_valid),  64'd1);
        chk("wd_hold_txv", 64'(bus.tx_valid), 64'd0);
        chk("wd_hold_pc",  64'(pkt_count),    64'd12);
        tick();

        // Reset mid-packet: req1 4-beat packet, reset after beat 2.
        ARESET_N = 1'b0;
        #1;
        tick();
        ARESET_N      = 1'b1;
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0000;
        #1;
        chk("rm_idle_txv", 64'(bus.tx_valid), 64'd0);
        tick();
        #1;
        chk("rm_b1_gid", 64'(grant_id),     64'd1);
        chk("rm_b1_txv", 64'(bus.tx_valid), 64'd1);
        tick();
        #1;
        chk("rm_b2_txv", 64'(bus.tx_valid), 64'd1);
        tick();
        ARESET_N      = 1'b0;
        bus.req_valid = 4'b0011;
        bus.req_last  = 4'b0001;
        #1;
        tick();
        ARESET_N = 1'b1;
        #1;
        chk("rm_txv", 64'(bus.tx_valid), 64'd0);
        chk("rm_gv",  64'(grant_valid),  64'd0);
        chk("rm_pc",  64'(pkt_count),    64'd0);
        chk("rm_ovr", 64'(overrun),      64'd0);
        chk("rm_rdy", 64'(bus.req_rdy),  64'd0);
        tick();
        #1;
        chk("rm_g_gv",  64'(grant_valid),  64'd1);
        chk("rm_g_gid", 64'(grant_id),     64'd0);
        chk("rm_g_rdy", 64'(bus.req_rdy),  64'd1);
        tick();
        bus.req_valid = 4'b0000;
        #1;
        chk("rm_end_pc", 64'(pkt_count),   64'd1);
        chk("rm_end_gv", 64'(grant_valid), 64'd0);

        // Counter wrap.
        force dut.pkt_count = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_count;
        #1;
        chk("wr_pre_pc", 64'(pkt_count), 64'hFFFF_FFFF);
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0100;
        tick();
        #1;
        chk("wr_gid", 64'(grant_id), 64'd2);
        tick();
        bus.req_valid = 4'b0000;
        #1;
        chk("wr_pc", 64'(pkt_count),   64'd0);
        chk("wr_gv", 64'(grant_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
